// File: rtl/player_input_arbiter.sv
// Player buzzer input arbiter.
// Conditions four raw buzzer buttons (synchronize, debounce, edge-detect)
// and latches the first player to press during a round until the CPU re-arms.
module player_input_arbiter #(
   parameter int DEBOUNCE_COUNT = 50000,
   parameter int CNT_BITS       = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] buttons,
   input  logic       gameHasStarted,
   input  logic       clear,
   output logic       playerInputFlag,
   output logic [1:0] firstPlayerFlag,
   output logic       allButtons,
   output logic [3:0] pressPulse
);

   // Terminal count of the debounce counter; the level flips on the edge
   // where the counter sits here and the input still disagrees.
   localparam logic [CNT_BITS-1:0] LP_CNT_MAX = CNT_BITS'(DEBOUNCE_COUNT - 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ARMED  = 2'd1,
      ST_LOCKED = 2'd2
   } state_t;

   logic [3:0]          r_sync1;
   logic [3:0]          r_sync2;
   logic [3:0]          r_deb;
   logic [3:0]          r_debD;
   logic [CNT_BITS-1:0] r_cnt [4];
   state_t              r_state;
   logic                r_playerInputFlag;
   logic [1:0]          r_firstPlayerFlag;

   logic [3:0]          w_pressPulse;
   logic [1:0]          w_winner;

   // Two-flop synchronizer bringing the asynchronous buttons into the clock domain.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync1 <= 4'b0000;
         r_sync2 <= 4'b0000;
      end else begin
         r_sync1 <= buttons;
         r_sync2 <= r_sync1;
      end
   end

   // Per-button debounce: a level change is accepted only after DEBOUNCE_COUNT
   // consecutive disagreeing cycles; any agreeing cycle restarts the count.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_deb <= 4'b0000;
         for (int i = 0; i < 4; i++) begin
            r_cnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (r_sync2[i] == r_deb[i]) begin
               r_cnt[i] <= '0;
            end else if (r_cnt[i] == LP_CNT_MAX) begin
               r_deb[i] <= r_sync2[i];
               r_cnt[i] <= '0;
            end else begin
               r_cnt[i] <= r_cnt[i] + CNT_BITS'(1);
            end
         end
      end
   end

   // Delayed copy of the debounced levels for rising-edge detection.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_debD <= 4'b0000;
      end else begin
         r_debD <= r_deb;
      end
   end

   assign w_pressPulse = r_deb & ~r_debD;

   // Lowest-index press wins a tie, so player 1 has priority on simultaneous presses.
   always_comb begin
      w_winner = 2'd0;
      if (w_pressPulse[0]) begin
         w_winner = 2'd0;
      end else if (w_pressPulse[1]) begin
         w_winner = 2'd1;
      end else if (w_pressPulse[2]) begin
         w_winner = 2'd2;
      end else if (w_pressPulse[3]) begin
         w_winner = 2'd3;
      end
   end

   // Round FSM: a dropped gameHasStarted beats clear, and clear beats a new
   // press, so a press arriving with clear in LOCKED is thrown away.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state           <= ST_IDLE;
         r_playerInputFlag <= 1'b0;
         r_firstPlayerFlag <= 2'd0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_playerInputFlag <= 1'b0;
               r_firstPlayerFlag <= 2'd0;
               if (gameHasStarted) begin
                  r_state <= ST_ARMED;
               end
            end
            ST_ARMED: begin
               if (!gameHasStarted) begin
                  r_state           <= ST_IDLE;
                  r_playerInputFlag <= 1'b0;
                  r_firstPlayerFlag <= 2'd0;
               end else if (|w_pressPulse) begin
                  r_state           <= ST_LOCKED;
                  r_playerInputFlag <= 1'b1;
                  r_firstPlayerFlag <= w_winner;
               end
            end
            ST_LOCKED: begin
               if (!gameHasStarted) begin
                  r_state           <= ST_IDLE;
                  r_playerInputFlag <= 1'b0;
                  r_firstPlayerFlag <= 2'd0;
               end else if (clear) begin
                  r_state           <= ST_ARMED;
                  r_playerInputFlag <= 1'b0;
               end
            end
            default: begin
               r_state           <= ST_IDLE;
               r_playerInputFlag <= 1'b0;
               r_firstPlayerFlag <= 2'd0;
            end
         endcase
      end
   end

   assign playerInputFlag = r_playerInputFlag;
   assign firstPlayerFlag = r_firstPlayerFlag;
   assign allButtons      = &r_deb;
   assign pressPulse      = w_pressPulse;

endmodule

// File: tb/tb_player_input_arbiter.sv
// Testbench for player_input_arbiter with a short debounce (4 cycles).
// Directed stimulus pushes expected press strobes and latched winners into
// queues; a monitor on the falling edge pops and compares them, while the
// stimulus thread also checks steady-state outputs at fixed points.
`timescale 1ns/1ps
module tb_player_input_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] buttons;
   logic       gameHasStarted;
   logic       clear;
   logic       playerInputFlag;
   logic [1:0] firstPlayerFlag;
   logic       allButtons;
   logic [3:0] pressPulse;

   int checkCount = 0;
   int passCount  = 0;

   logic [3:0] pulseQ [$];
   logic [1:0] latchQ [$];
   logic       prevFlag = 1'b0;
   logic [3:0] expPulse;
   logic [1:0] expWinner;

   player_input_arbiter #(
      .DEBOUNCE_COUNT(4),
      .CNT_BITS(16)
   ) dut (
      .clk(clk),
      .rst(rst),
      .buttons(buttons),
      .gameHasStarted(gameHasStarted),
      .clear(clear),
      .playerInputFlag(playerInputFlag),
      .firstPlayerFlag(firstPlayerFlag),
      .allButtons(allButtons),
      .pressPulse(pressPulse)
   );

   // Free-running 100 MHz clock.
   always #5 clk = ~clk;

   // One comparison: counts it, and reports it only when it does not match.
   task automatic checkOutput(input string name, input int actual, input int expected);
      checkCount++;
      if (actual == expected) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // Drive all non-reset inputs at once.
   task automatic applyStimulus(input logic [3:0] b, input logic g, input logic c);
      buttons        = b;
      gameHasStarted = g;
      clear          = c;
   endtask

   // Record that a debounced rise with this strobe vector is coming, and
   // whether it should produce a fresh winner latch.
   task automatic expectPress(input logic [3:0] pulse, input logic doLatch, input logic [1:0] winner);
      pulseQ.push_back(pulse);
      if (doLatch) begin
         latchQ.push_back(winner);
      end
   endtask

   // Advance n rising edges and settle just after the last one.
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Monitor: every visible press strobe and every rising playerInputFlag must
   // match the next queued expectation; anything unqueued is an error.
   always @(negedge clk) begin
      if (pressPulse != 4'b0000) begin
         if (pulseQ.size() == 0) begin
            checkOutput("unexpected pressPulse", int'(pressPulse), 0);
         end else begin
            expPulse = pulseQ.pop_front();
            checkOutput("pressPulse event", int'(pressPulse), int'(expPulse));
         end
      end
      if (playerInputFlag && !prevFlag) begin
         if (latchQ.size() == 0) begin
            checkOutput("unexpected winner latch", int'(firstPlayerFlag), -1);
         end else begin
            expWinner = latchQ.pop_front();
            checkOutput("latched winner", int'(firstPlayerFlag), int'(expWinner));
         end
      end
      prevFlag = playerInputFlag;
   end

   // Hard time limit so the run can never hang.
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: time %0t reached limit 100000", $time);
      $fatal(1);
   end

   // Directed test sequence.
   initial begin
      rst = 1'b1;
      applyStimulus(4'b0000, 1'b0, 1'b0);
      tick(2);
      checkOutput("reset playerInputFlag", int'(playerInputFlag), 0);
      checkOutput("reset firstPlayerFlag", int'(firstPlayerFlag), 0);
      checkOutput("reset allButtons", int'(allButtons), 0);
      checkOutput("reset pressPulse", int'(pressPulse), 0);
      rst = 1'b0;
      tick(1);

      // Single press by P3 and latency of the strobe and the latch.
      applyStimulus(4'b0000, 1'b1, 1'b0);
      tick(1);
      expectPress(4'b0100, 1'b1, 2'd2);
      applyStimulus(4'b0100, 1'b1, 1'b0);
      tick(5);
      checkOutput("no pulse before edge 6", int'(pressPulse), 0);
      tick(1);
      checkOutput("pulse after edge 6", int'(pressPulse), 4'b0100);
      checkOutput("flag still low after edge 6", int'(playerInputFlag), 0);
      tick(1);
      checkOutput("pulse one cycle only", int'(pressPulse), 0);
      checkOutput("flag after edge 7", int'(playerInputFlag), 1);
      checkOutput("winner P3", int'(firstPlayerFlag), 2);
      tick(3);
      checkOutput("flag holds", int'(playerInputFlag), 1);
      checkOutput("winner holds", int'(firstPlayerFlag), 2);

      // Re-arm, release, then a 3-cycle glitch on P2 must be rejected.
      applyStimulus(4'b0100, 1'b1, 1'b1);
      tick(1);
      applyStimulus(4'b0100, 1'b1, 1'b0);
      checkOutput("clear drops flag", int'(playerInputFlag), 0);
      checkOutput("clear keeps winner", int'(firstPlayerFlag), 2);
      applyStimulus(4'b0000, 1'b1, 1'b0);
      tick(8);
      applyStimulus(4'b0010, 1'b1, 1'b0);
      tick(3);
      applyStimulus(4'b0000, 1'b1, 1'b0);
      tick(10);
      checkOutput("glitch rejected", int'(playerInputFlag), 0);

      // Simultaneous P2+P4: P2 wins; a later P1 press while locked is ignored.
      expectPress(4'b1010, 1'b1, 2'd1);
      applyStimulus(4'b1010, 1'b1, 1'b0);
      tick(7);
      checkOutput("simultaneous flag", int'(playerInputFlag), 1);
      checkOutput("simultaneous winner P2", int'(firstPlayerFlag), 1);
      expectPress(4'b0001, 1'b0, 2'd0);
      applyStimulus(4'b1011, 1'b1, 1'b0);
      tick(8);
      checkOutput("locked ignores P1 flag", int'(playerInputFlag), 1);
      checkOutput("locked ignores P1 winner", int'(firstPlayerFlag), 1);

      // Clear with buttons held; held buttons must not win after re-arm.
      applyStimulus(4'b1011, 1'b1, 1'b1);
      tick(1);
      applyStimulus(4'b1011, 1'b1, 1'b0);
      checkOutput("re-arm flag low", int'(playerInputFlag), 0);
      checkOutput("re-arm winner kept", int'(firstPlayerFlag), 1);
      tick(8);
      checkOutput("held buttons do not win", int'(playerInputFlag), 0);
      applyStimulus(4'b0000, 1'b1, 1'b0);
      tick(8);
      expectPress(4'b1000, 1'b1, 2'd3);
      applyStimulus(4'b1000, 1'b1, 1'b0);
      tick(7);
      checkOutput("P4 flag", int'(playerInputFlag), 1);
      checkOutput("P4 winner", int'(firstPlayerFlag), 3);

      // Clear in the same cycle as a press strobe: press discarded.
      expectPress(4'b0001, 1'b0, 2'd0);
      applyStimulus(4'b1001, 1'b1, 1'b0);
      tick(6);
      checkOutput("strobe coincident with clear", int'(pressPulse), 4'b0001);
      applyStimulus(4'b1001, 1'b1, 1'b1);
      tick(1);
      applyStimulus(4'b1001, 1'b1, 1'b0);
      checkOutput("clear beats press flag", int'(playerInputFlag), 0);
      checkOutput("clear beats press winner", int'(firstPlayerFlag), 3);
      tick(3);
      checkOutput("discarded press not relatched", int'(playerInputFlag), 0);

      // Lock on P2, then drop gameHasStarted; presses in IDLE never latch.
      expectPress(4'b0010, 1'b1, 2'd1);
      applyStimulus(4'b1011, 1'b1, 1'b0);
      tick(7);
      checkOutput("lock before game drop", int'(playerInputFlag), 1);
      applyStimulus(4'b1011, 1'b0, 1'b0);
      tick(1);
      checkOutput("game drop flag", int'(playerInputFlag), 0);
      checkOutput("game drop winner", int'(firstPlayerFlag), 0);
      applyStimulus(4'b0000, 1'b0, 1'b0);
      tick(8);
      expectPress(4'b0100, 1'b0, 2'd0);
      applyStimulus(4'b0100, 1'b0, 1'b0);
      tick(10);
      checkOutput("press in IDLE", int'(playerInputFlag), 0);

      // allButtons rises once all four levels are debounced, falls on a release.
      expectPress(4'b1011, 1'b0, 2'd0);
      applyStimulus(4'b1111, 1'b0, 1'b0);
      tick(5);
      checkOutput("allButtons before debounce", int'(allButtons), 0);
      tick(1);
      checkOutput("allButtons set", int'(allButtons), 1);
      tick(3);
      checkOutput("allButtons held", int'(allButtons), 1);
      applyStimulus(4'b0111, 1'b0, 1'b0);
      tick(5);
      checkOutput("allButtons before release debounce", int'(allButtons), 1);
      tick(1);
      checkOutput("allButtons released", int'(allButtons), 0);

      // Lock on P4 with all buttons held, then reset mid-sequence.
      applyStimulus(4'b0111, 1'b1, 1'b0);
      tick(1);
      expectPress(4'b1000, 1'b1, 2'd3);
      applyStimulus(4'b1111, 1'b1, 1'b0);
      tick(7);
      checkOutput("pre-reset flag", int'(playerInputFlag), 1);
      checkOutput("pre-reset winner", int'(firstPlayerFlag), 3);
      checkOutput("pre-reset allButtons", int'(allButtons), 1);
      rst = 1'b1;
      applyStimulus(4'b0000, 1'b1, 1'b0);
      tick(1);
      checkOutput("mid reset flag", int'(playerInputFlag), 0);
      checkOutput("mid reset winner", int'(firstPlayerFlag), 0);
      checkOutput("mid reset allButtons", int'(allButtons), 0);
      checkOutput("mid reset pressPulse", int'(pressPulse), 0);
      rst = 1'b0;
      tick(12);
      checkOutput("no latch after reset", int'(playerInputFlag), 0);

      // Every queued expectation must have been seen by the monitor.
      tick(2);
      checkOutput("pending pressPulse events", pulseQ.size(), 0);
      checkOutput("pending winner latches", latchQ.size(), 0);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
